neuron_spi_tx: RTL and testbench
================================

Name: neuron_spi_tx

Overview:
Downstream return path for the single-neuron datapath: captures the 8-bit neuron result and shifts it back to the external SPI master on MISO. SPI mode 0 slave, MSB first, sharing cs/sck with the existing SPI receiver. Fully synchronous to clk; cs/sck are oversampled through synchronizers, and clk must be at least 8x the sck frequency.

Parameters:
DATA_W, 8, result width and shift length in bits
SYNC_STAGES, 2, flip-flop depth of the cs/sck synchronizers (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cs  input  1  SPI chip select, active low, asynchronous to clk
sck  input  1  SPI clock, asynchronous to clk; idles low
neuron_out  input  DATA_W  neuron result
result_load  input  1  one-clk strobe: neuron_out is valid this cycle
miso  output  1  serial data out
miso_oe  output  1  high while a transaction is active (pad tristate enable)
busy  output  1  high from transaction start until cs deassertion
tx_done  output  1  one-clk pulse after each complete DATA_W-bit byte
overrun  output  1  sticky: a new result arrived before the previous one was read

Behaviour:
- Reset (async, rst=1): all outputs 0; holding reg = 0; shift reg = 0; bit_cnt = 0; fresh = 0; state = IDLE; synchronizer flops = idle levels (cs=1, sck=0).
- Sync: cs and sck each pass through SYNC_STAGES flops. Edges are detected on the synchronized signals: cs_fall, cs_rise, sck_rise, sck_fall.
- Holding reg: on result_load, capture neuron_out and set fresh=1. If fresh is already 1, set overrun=1.
- State IDLE: miso=0, miso_oe=0, busy=0. On cs_fall: load shift reg from the holding reg, clear fresh, clear overrun, bit_cnt=0, set busy=1 and miso_oe=1, and go to SHIFT. The shift reg MSB drives miso on the next clk.
- Simultaneous result_load and cs_fall: bypass, so the shift reg takes neuron_out directly. fresh ends at 0 and overrun is not set.
- State SHIFT:
  - sck_rise: master samples; increment bit_cnt.
  - sck_fall: shift left one bit and present the next bit on miso.
  - When bit_cnt reaches DATA_W on sck_rise: pulse tx_done for 1 clk, wrap bit_cnt to 0, reload the shift reg from the holding reg on the following sck_fall, and clear fresh. A long cs-low transfer therefore streams the latest result repeatedly.
- cs_rise in any state: return to IDLE next clk, bit_cnt=0, miso=0, miso_oe=0, busy=0. A partial byte raises no tx_done, and fresh is not restored.
- A result_load during SHIFT updates only the holding reg; the byte in flight is never corrupted.
- sck edges while cs is high are ignored.
- Latency: miso changes SYNC_STAGES+1 clk after the sck falling edge at the pin.

Optional Feature:
Macro: NEURON_SPI_TX_STATUS_EN
- Defined: each transaction first sends one status byte, {fresh, overrun, DATA_W-2 bits of zero}, sampled at cs_fall before the clears; the result byte(s) follow. tx_done pulses for the status byte too.
- Undefined: the first byte is the result and no status byte exists.

Decomposition:
- Shared package neuron_pkg: DATA_W constant, the state enum {IDLE, SHIFT} (plus STATUS when the feature is enabled), and the status-byte bit positions.
- One sub-module: sync_edge_det, an N-stage synchronizer with rise/fall pulse outputs, instantiated for cs and sck.

Test Plan:
- Reset mid-transaction: assert rst during bit 4 -> miso=0, miso_oe=0, busy=0 within the same clk (async). A following transaction sends holding=0x00.
- Basic read: result_load with 0xA5, then cs low and 8 sck cycles at clk/16 -> master samples 1,0,1,0,0,1,0,1. tx_done pulses once and overrun stays 0.
- Overrun: load 0x11 then 0x22 with no read -> overrun=1 and the read returns 0x22. After cs falls, overrun=0.
- Simultaneous load/start: result_load with 0x3C on the same clk as the synchronized cs_fall -> 0x3C is shifted out and fresh=0 afterwards.
- Abort and stream: cs high after 5 bits -> no tx_done and busy drops. Then a 16-sck transfer with holding 0x81 -> 0x81 sent twice with two tx_done pulses.
- With NEURON_SPI_TX_STATUS_EN: load 0x11 and 0x22, then 16 sck -> bytes 0xC0 then 0x22.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron SPI return path: result width, transmitter
// FSM states and the layout of the optional status byte.
package neuron_pkg;

    // Neuron result width, also the SPI shift length.
    localparam int unsigned DATA_W = 8;

    // Status byte layout, as offsets from the MSB: {fresh, overrun, zeros}.
    localparam int unsigned StatFreshMsbOfs   = 0;
    localparam int unsigned StatOverrunMsbOfs = 1;

`ifdef NEURON_SPI_TX_STATUS_EN
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStatus
    } tx_state_e;
`else
    typedef enum logic [0:0] {
        StIdle,
        StShift
    } tx_state_e;
`endif

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer for an asynchronous level, with single-cycle rise and
// fall pulses derived from the synchronized level.
module sync_edge_det #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/neuron_spi_tx.sv
// SPI mode 0 slave transmitter returning the neuron result to the master on
// MISO, MSB first. cs/sck are oversampled in the clk domain.
// Optional build macro NEURON_SPI_TX_STATUS_EN: prefix every transaction with
// a status byte {fresh, overrun, zeros} sampled at transaction start.
module neuron_spi_tx
    import neuron_pkg::*;
#(
    parameter int unsigned DATA_W      = neuron_pkg::DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sck,
    input  logic [DATA_W-1:0] neuron_out,
    input  logic              result_load,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy,
    output logic              tx_done,
    output logic              overrun
);

    localparam int unsigned       CntW    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0]   LastBit = CntW'(DATA_W - 1);
`ifdef NEURON_SPI_TX_STATUS_EN
    localparam tx_state_e         FirstSt = StStatus;
`else
    localparam tx_state_e         FirstSt = StShift;
`endif

    logic cs_rise, cs_fall, sck_rise, sck_fall;

    sync_edge_det #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_cs_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge_det #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_sck_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    tx_state_e         state_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic              fresh_q;
    logic              overrun_q;
    logic              reload_q;   // next sck fall starts a new byte from hold_q
    logic              miso_q;
    logic              miso_oe_q;
    logic              busy_q;
    logic              tx_done_q;
    logic [DATA_W-1:0] first_byte;

    // First byte loaded at cs fall: status byte, or the result with a bypass
    // so a result arriving on the start cycle is the one sent.
    always_comb begin
        first_byte = '0;
`ifdef NEURON_SPI_TX_STATUS_EN
        first_byte[DATA_W-1-StatFreshMsbOfs]   = fresh_q;
        first_byte[DATA_W-1-StatOverrunMsbOfs] = overrun_q;
`else
        first_byte = result_load ? neuron_out : hold_q;
`endif
    end

    // Holding register, status flags and the transmit FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            fresh_q   <= 1'b0;
            overrun_q <= 1'b0;
            reload_q  <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;

            if (result_load) begin
                hold_q  <= neuron_out;
                fresh_q <= 1'b1;
                if (fresh_q) begin
                    overrun_q <= 1'b1;
                end
            end

            if (cs_rise) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                reload_q  <= 1'b0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (state_q == StIdle) begin
                if (cs_fall) begin
                    shift_q   <= first_byte;
                    miso_q    <= first_byte[DATA_W-1];
                    fresh_q   <= 1'b0;
                    overrun_q <= 1'b0;
                    bit_cnt_q <= '0;
                    reload_q  <= 1'b0;
                    busy_q    <= 1'b1;
                    miso_oe_q <= 1'b1;
                    state_q   <= FirstSt;
                end
            end else begin
                // Master samples on sck rise; the byte ends on its last rise.
                if (sck_rise) begin
                    if (bit_cnt_q == LastBit) begin
                        tx_done_q <= 1'b1;
                        bit_cnt_q <= '0;
                        reload_q  <= 1'b1;
                        state_q   <= StShift;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                // Next bit goes out on sck fall; a finished byte restarts from hold_q.
                if (sck_fall) begin
                    if (reload_q) begin
                        shift_q  <= hold_q;
                        miso_q   <= hold_q[DATA_W-1];
                        reload_q <= 1'b0;
                        if (!result_load) begin
                            fresh_q <= 1'b0;
                        end
                    end else begin
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        miso_q  <= shift_q[DATA_W-2];
                    end
                end
            end
        end
    end

    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_neuron_spi_tx.sv
// Directed bench for neuron_spi_tx: SPI master model at clk/16 with
// hand-computed expected bytes.
module tb_neuron_spi_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       sck;
    logic [7:0] neuron_out;
    logic       result_load;
    logic       miso;
    logic       miso_oe;
    logic       busy;
    logic       tx_done;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int done_total = 0;

    neuron_spi_tx #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .sck         (sck),
        .neuron_out  (neuron_out),
        .result_load (result_load),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Count tx_done pulses away from the active edge.
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        neuron_out  = v;
        result_load = 1'b1;
        @(negedge clk);
        result_load = 1'b0;
    endtask

    // One cs-low transfer of nbits sck periods (16 clk each); optionally pulses
    // result_load on the cycle the synchronized cs fall reaches the FSM.
    task automatic xfer(input int nbits, input bit sim_load, input logic [7:0] v,
                        output logic [31:0] rx, output int ndone);
        int start;
        start = done_total;
        rx    = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        if (sim_load) begin
            neuron_out  = v;
            result_load = 1'b1;
        end
        @(negedge clk);
        result_load = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_active", 32'(busy), 32'd1);
        check("oe_active", 32'(miso_oe), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            rx  = {rx[30:0], miso};
            repeat (8) @(negedge clk);
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        ndone = done_total - start;
    endtask

    initial begin
        logic [31:0] rx;
        int          nd;

        rst         = 1'b1;
        cs          = 1'b1;
        sck         = 1'b0;
        neuron_out  = '0;
        result_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

`ifdef NEURON_SPI_TX_STATUS_EN
        // Status byte then result.
        load(8'h11);
        load(8'h22);
        check("st_overrun_set", 32'(overrun), 32'd1);
        xfer(16, 1'b0, 8'h00, rx, nd);
        check("st_bytes", rx, 32'h0000C022);
        check("st_done_cnt", 32'(nd), 32'd2);
        check("st_overrun_clr", 32'(overrun), 32'd0);
        check("st_busy_end", 32'(busy), 32'd0);
`else
        // Basic read.
        load(8'hA5);
        xfer(8, 1'b0, 8'h00, rx, nd);
        check("basic_rx", rx, 32'h000000A5);
        check("basic_done_cnt", 32'(nd), 32'd1);
        check("basic_overrun", 32'(overrun), 32'd0);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_oe_end", 32'(miso_oe), 32'd0);

        // Overrun: second result before a read.
        load(8'h11);
        check("ovr_clear_one", 32'(overrun), 32'd0);
        load(8'h22);
        check("ovr_set", 32'(overrun), 32'd1);
        xfer(8, 1'b0, 8'h00, rx, nd);
        check("ovr_rx", rx, 32'h00000022);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Result arriving on the start cycle is sent directly; fresh ends 0.
        xfer(8, 1'b1, 8'h3C, rx, nd);
        check("sim_rx", rx, 32'h0000003C);
        check("sim_done_cnt", 32'(nd), 32'd1);
        load(8'h5A);
        check("sim_fresh_clr", 32'(overrun), 32'd0);

        // Abort after 5 bits of 0x5A.
        xfer(5, 1'b0, 8'h00, rx, nd);
        check("abort_rx", rx, 32'h0000000B);
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(miso_oe), 32'd0);

        // Streaming: 16 sck repeats the held result.
        load(8'h81);
        check("stream_no_ovr", 32'(overrun), 32'd0);
        xfer(16, 1'b0, 8'h00, rx, nd);
        check("stream_rx", rx, 32'h00008181);
        check("stream_done_cnt", 32'(nd), 32'd2);

        // Asynchronous reset during bit 4.
        load(8'hFF);
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        repeat (3) begin
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
        sck = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_miso", 32'(miso), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_miso", 32'(miso), 32'd0);
        check("arst_oe", 32'(miso_oe), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        cs  = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(8, 1'b0, 8'h00, rx, nd);
        check("post_rst_rx", rx, 32'h00000000);
        check("post_rst_done", 32'(nd), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
